// File: rtl/timer_pkg.sv
// Shared definitions for the Game Boy style timer: register offsets,
// TAC field positions and the overflow-sequencing state type.
package timer_pkg;

    localparam logic [15:0] OFS_DIV  = 16'd0;
    localparam logic [15:0] OFS_TIMA = 16'd1;
    localparam logic [15:0] OFS_TMA  = 16'd2;
    localparam logic [15:0] OFS_TAC  = 16'd3;

    localparam int TAC_EN_BIT  = 2;
    localparam int TAC_SEL_MSB = 1;
    localparam int TAC_SEL_LSB = 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        RELOAD = 2'd2
    } ovf_state_e;

endpackage

// File: rtl/timer_div_counter.sv
// Free-running divider with tap mux and falling-edge detector; the tick
// fires in the same clock the selected (enabled) divider bit drops.
module timer_div_counter
    import timer_pkg::*;
#(
    parameter int DIV_W = 16,
    parameter int TAP0  = 9,
    parameter int TAP1  = 3,
    parameter int TAP2  = 5,
    parameter int TAP3  = 7
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       div_clr_i,
    input  logic       tac_en_i,
    input  logic [1:0] tac_sel_i,
    output logic [7:0] div_o,
    output logic       tick_o
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             sig_q, sig_d;
    logic             tap_bit;

    // Edge detection compares the post-edge signal against the stored one,
    // so DIV clears and TAC rewrites produce ticks just like counting does.
    always_comb begin
        cnt_d   = div_clr_i ? '0 : cnt_q + DIV_W'(1);
        tap_bit = 1'b0;
        unique case (tac_sel_i)
            2'b00:   tap_bit = cnt_d[TAP0];
            2'b01:   tap_bit = cnt_d[TAP1];
            2'b10:   tap_bit = cnt_d[TAP2];
            default: tap_bit = cnt_d[TAP3];
        endcase
        sig_d  = tac_en_i & tap_bit;
        tick_o = sig_q & ~sig_d;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            sig_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sig_q <= sig_d;
        end
    end

    assign div_o = cnt_q[DIV_W-1 -: 8];

endmodule

// File: rtl/gb_timer_param.sv
// Game Boy timer (DIV/TIMA/TMA/TAC). Define TIMER_OVF_DELAY_EN for the
// 4-clock overflow window before reload; otherwise reload is immediate.
module gb_timer_param
    import timer_pkg::*;
#(
    parameter int          DIV_W     = 16,
    parameter logic [15:0] BASE_ADDR = 16'hFF04,
    parameter int          TAP0      = 9,
    parameter int          TAP1      = 3,
    parameter int          TAP2      = 5,
    parameter int          TAP3      = 7
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [15:0] A_mmu,
    input  logic [7:0]  Di_mmu,
    output logic [7:0]  Do_mmu,
    input  logic        wr_mmu,
    input  logic        rd_mmu,
    input  logic        cs_mmu,
    output logic        timerIRQ
);

    localparam logic [15:0] ADDR_DIV  = BASE_ADDR + OFS_DIV;
    localparam logic [15:0] ADDR_TIMA = BASE_ADDR + OFS_TIMA;
    localparam logic [15:0] ADDR_TMA  = BASE_ADDR + OFS_TMA;
    localparam logic [15:0] ADDR_TAC  = BASE_ADDR + OFS_TAC;

    logic [7:0] tima_q, tma_q, tma_d;
    logic [2:0] tac_q, tac_d;
    logic       irq_q;
    logic [7:0] div_byte;
    logic       tick;
    logic       wr_en, rd_en;
    logic       wr_div, wr_tima, wr_tma, wr_tac;

    assign wr_en   = cs_mmu & wr_mmu;
    assign rd_en   = cs_mmu & rd_mmu;
    assign wr_div  = wr_en & (A_mmu == ADDR_DIV);
    assign wr_tima = wr_en & (A_mmu == ADDR_TIMA);
    assign wr_tma  = wr_en & (A_mmu == ADDR_TMA);
    assign wr_tac  = wr_en & (A_mmu == ADDR_TAC);

    assign tac_d = wr_tac ? Di_mmu[2:0] : tac_q;
    assign tma_d = wr_tma ? Di_mmu : tma_q;

    // The divider sees next-state TAC so an enable/select change in this
    // clock is edge-detected in the same clock.
    timer_div_counter #(
        .DIV_W(DIV_W), .TAP0(TAP0), .TAP1(TAP1), .TAP2(TAP2), .TAP3(TAP3)
    ) u_div (
        .clock     (clock),
        .reset_n   (reset_n),
        .div_clr_i (wr_div),
        .tac_en_i  (tac_d[TAC_EN_BIT]),
        .tac_sel_i (tac_d[TAC_SEL_MSB:TAC_SEL_LSB]),
        .div_o     (div_byte),
        .tick_o    (tick)
    );

`ifdef TIMER_OVF_DELAY_EN
    ovf_state_e ovf_q;
    logic [1:0] wcnt_q;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tima_q <= 8'h00;
            tma_q  <= 8'h00;
            tac_q  <= 3'b000;
            irq_q  <= 1'b0;
`ifdef TIMER_OVF_DELAY_EN
            ovf_q  <= IDLE;
            wcnt_q <= 2'd0;
`endif
        end else begin
            tma_q <= tma_d;
            tac_q <= tac_d;
            irq_q <= 1'b0;
`ifdef TIMER_OVF_DELAY_EN
            // TIMA holds 00 for four clocks; a CPU write anywhere in the
            // window (including the reload clock) aborts the reload.
            unique case (ovf_q)
                IDLE: begin
                    if (wr_tima) begin
                        tima_q <= Di_mmu;
                    end else if (tick) begin
                        if (tima_q == 8'hFF) begin
                            tima_q <= 8'h00;
                            ovf_q  <= WAIT;
                            wcnt_q <= 2'd0;
                        end else begin
                            tima_q <= tima_q + 8'd1;
                        end
                    end
                end
                WAIT: begin
                    if (wr_tima) begin
                        tima_q <= Di_mmu;
                        ovf_q  <= IDLE;
                    end else begin
                        wcnt_q <= wcnt_q + 2'd1;
                        if (wcnt_q == 2'd2) ovf_q <= RELOAD;
                    end
                end
                RELOAD: begin
                    ovf_q <= IDLE;
                    if (wr_tima) begin
                        tima_q <= Di_mmu;
                    end else begin
                        tima_q <= tma_d;
                        irq_q  <= 1'b1;
                    end
                end
                default: ovf_q <= IDLE;
            endcase
`else
            if (wr_tima) begin
                tima_q <= Di_mmu;
            end else if (tick) begin
                if (tima_q == 8'hFF) begin
                    tima_q <= tma_d;
                    irq_q  <= 1'b1;
                end else begin
                    tima_q <= tima_q + 8'd1;
                end
            end
`endif
        end
    end

    always_comb begin
        Do_mmu = 8'h00;
        if (rd_en) begin
            if (A_mmu == ADDR_DIV)       Do_mmu = div_byte;
            else if (A_mmu == ADDR_TIMA) Do_mmu = tima_q;
            else if (A_mmu == ADDR_TMA)  Do_mmu = tma_q;
            else if (A_mmu == ADDR_TAC)  Do_mmu = {5'b11111, tac_q};
        end
    end

    assign timerIRQ = irq_q;

endmodule

// File: tb/tb_gb_timer_param.sv
// Self-checking bench for gb_timer_param: register table, hand-written
// timing corner cases and randomized traffic against a behavioural model.
module tb_gb_timer_param;

    localparam int          DIV_W = 16;
    localparam logic [15:0] BASE  = 16'hFF04;
    localparam logic [15:0] A_DIV  = BASE;
    localparam logic [15:0] A_TIMA = BASE + 16'd1;
    localparam logic [15:0] A_TMA  = BASE + 16'd2;
    localparam logic [15:0] A_TAC  = BASE + 16'd3;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] A_mmu = '0;
    logic [7:0]  Di_mmu = '0;
    logic [7:0]  Do_mmu;
    logic        wr_mmu = 1'b0, rd_mmu = 1'b0, cs_mmu = 1'b0;
    logic        timerIRQ;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model state
    int m_cnt, m_tima, m_tma, m_tac, m_win, m_irq;

    gb_timer_param #(
        .DIV_W(DIV_W), .BASE_ADDR(BASE), .TAP0(9), .TAP1(3), .TAP2(5), .TAP3(7)
    ) dut (
        .clock(clock), .reset_n(reset_n), .A_mmu(A_mmu), .Di_mmu(Di_mmu),
        .Do_mmu(Do_mmu), .wr_mmu(wr_mmu), .rd_mmu(rd_mmu), .cs_mmu(cs_mmu),
        .timerIRQ(timerIRQ)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int tap_of(input int sel);
        case (sel)
            0: return 9;
            1: return 3;
            2: return 5;
            default: return 7;
        endcase
    endfunction

    function automatic bit sig_of(input int tac, input int cnt);
        return (((tac >> 2) & 1) == 1) && (((cnt >> tap_of(tac & 3)) & 1) == 1);
    endfunction

    function automatic int exp_read(input logic [15:0] a);
        if (a == A_DIV)  return (m_cnt >> (DIV_W - 8)) & 255;
        if (a == A_TIMA) return m_tima;
        if (a == A_TMA)  return m_tma;
        if (a == A_TAC)  return 248 + m_tac;
        return 0;
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_tima = 0; m_tma = 0; m_tac = 0; m_win = 0; m_irq = 0;
    endtask

    // One clock of the timer, straight from the register-level rules.
    task automatic model_step(input bit w, input logic [15:0] a, input logic [7:0] d);
        int  n_tac;
        int  n_tma;
        int  n_cnt;
        bit  fall;
        n_tac = (w && a == A_TAC) ? int'(d) & 7 : m_tac;
        n_tma = (w && a == A_TMA) ? int'(d) : m_tma;
        n_cnt = (w && a == A_DIV) ? 0 : (m_cnt + 1) % (1 << DIV_W);
        fall  = sig_of(m_tac, m_cnt) && !sig_of(n_tac, n_cnt);
        m_irq = 0;
`ifdef TIMER_OVF_DELAY_EN
        if (m_win > 0) begin
            if (w && a == A_TIMA) begin
                m_tima = int'(d);
                m_win  = 0;
            end else begin
                m_win--;
                if (m_win == 0) begin
                    m_tima = n_tma;
                    m_irq  = 1;
                end
            end
        end else if (w && a == A_TIMA) begin
            m_tima = int'(d);
        end else if (fall) begin
            if (m_tima == 255) begin
                m_tima = 0;
                m_win  = 4;
            end else begin
                m_tima++;
            end
        end
`else
        if (w && a == A_TIMA) begin
            m_tima = int'(d);
        end else if (fall) begin
            if (m_tima == 255) begin
                m_tima = n_tma;
                m_irq  = 1;
            end else begin
                m_tima++;
            end
        end
`endif
        m_tac = n_tac;
        m_tma = n_tma;
        m_cnt = n_cnt;
    endtask

    task automatic cyc(input logic c, input logic w, input logic r,
                       input logic [15:0] a, input logic [7:0] d);
        cs_mmu = c; wr_mmu = w; rd_mmu = r; A_mmu = a; Di_mmu = d;
        @(posedge clock);
        model_step(c & w, a, d);
        @(negedge clock);
        cs_mmu = 1'b0; wr_mmu = 1'b0; rd_mmu = 1'b0;
        check("irq", int'(timerIRQ), m_irq);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, A_DIV, 8'h00);
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        $display("write  addr=%h data=%h", a, d);
        cyc(1'b1, 1'b1, 1'b0, a, d);
    endtask

    // Combinational read, checked both against a constant and the model.
    task automatic peek(input string name, input logic [15:0] a, input int exp);
        cs_mmu = 1'b1; rd_mmu = 1'b1; wr_mmu = 1'b0; A_mmu = a;
        #1;
        $display("read   %s addr=%h data=%h", name, a, Do_mmu);
        check(name, int'(Do_mmu), exp);
        check({name, "_model"}, int'(Do_mmu), exp_read(a));
        cs_mmu = 1'b0; rd_mmu = 1'b0;
    endtask

    // Leaves TIMA=FF, TMA=F0, TAC=100 one clock before the overflow edge.
    task automatic setup_overflow();
        wr(A_TAC, 8'h04);
        wr(A_TMA, 8'hF0);
        wr(A_DIV, 8'h00);
        wr(A_TIMA, 8'hFF);
        idle(1022);
        peek("pre_ovf_tima", A_TIMA, 8'hFF);
    endtask

    typedef struct {
        logic        cs;
        logic        wr;
        logic        rd;
        logic [15:0] addr;
        logic [7:0]  din;
        logic [7:0]  exp_do;
    } vec_t;

    vec_t vecs[17];

    initial begin
        vecs[0]  = '{1'b1, 1'b1, 1'b0, A_TMA,  8'h5A, 8'h00};
        vecs[1]  = '{1'b1, 1'b0, 1'b1, A_TMA,  8'h00, 8'h5A};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, A_TAC,  8'hFA, 8'h00};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, A_TAC,  8'h00, 8'hFA};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, A_TIMA, 8'h33, 8'h00};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, A_TIMA, 8'h00, 8'h33};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, A_TAC,  8'h07, 8'h00};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, A_TAC,  8'h00, 8'hFA};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 16'hFF08, 8'h00, 8'h00};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, A_TIMA, 8'h00, 8'h00};
        vecs[10] = '{1'b1, 1'b1, 1'b0, A_DIV,  8'hFF, 8'h00};
        vecs[11] = '{1'b1, 1'b0, 1'b1, A_DIV,  8'h00, 8'h00};
        vecs[12] = '{1'b1, 1'b0, 1'b1, 16'hFF03, 8'h00, 8'h00};
        vecs[13] = '{1'b1, 1'b1, 1'b1, A_TMA,  8'h77, 8'h5A};
        vecs[14] = '{1'b1, 1'b0, 1'b1, A_TMA,  8'h00, 8'h77};
        vecs[15] = '{1'b1, 1'b1, 1'b0, A_TAC,  8'h00, 8'h00};
        vecs[16] = '{1'b1, 1'b0, 1'b1, A_TAC,  8'h00, 8'hF8};

        // Reset state
        model_reset();
        repeat (3) @(negedge clock);
        check("rst_irq", int'(timerIRQ), 0);
        peek("rst_div", A_DIV, 8'h00);
        peek("rst_tima", A_TIMA, 8'h00);
        peek("rst_tma", A_TMA, 8'h00);
        peek("rst_tac", A_TAC, 8'hF8);
        reset_n = 1'b1;

        // Register access table
        for (int i = 0; i < 17; i++) begin
            cs_mmu = vecs[i].cs; wr_mmu = vecs[i].wr; rd_mmu = vecs[i].rd;
            A_mmu = vecs[i].addr; Di_mmu = vecs[i].din;
            #1;
            $display("vec %0d cs=%b wr=%b rd=%b addr=%h din=%h do=%h",
                     i, vecs[i].cs, vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].din, Do_mmu);
            check($sformatf("vec%0d", i), int'(Do_mmu), int'(vecs[i].exp_do));
            cyc(vecs[i].cs, vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].din);
        end

        // 16-clock tick period with TAC=101
        wr(A_TAC, 8'h05);
        wr(A_DIV, 8'h00);
        wr(A_TIMA, 8'h00);
        idle(14);
        peek("p16_before", A_TIMA, 8'h00);
        idle(1);
        peek("p16_first", A_TIMA, 8'h01);
        idle(15);
        peek("p16_hold", A_TIMA, 8'h01);
        idle(1);
        peek("p16_second", A_TIMA, 8'h02);

        // DIV write / TAC enable clear / select change produce ticks
        wr(A_DIV, 8'h00);
        wr(A_TIMA, 8'h10);
        idle(7);
        wr(A_DIV, 8'h5C);
        peek("divclr_div", A_DIV, 8'h00);
        peek("divclr_tima", A_TIMA, 8'h11);
        idle(8);
        wr(A_TAC, 8'h01);
        peek("tacoff_tima", A_TIMA, 8'h12);
        wr(A_TAC, 8'h05);
        peek("tacon_tima", A_TIMA, 8'h12);
        wr(A_TAC, 8'h06);
        peek("tacsel_tima", A_TIMA, 8'h13);

        // Overflow and reload timing
        setup_overflow();
        idle(1);
`ifdef TIMER_OVF_DELAY_EN
        check("ovf_irq0", int'(timerIRQ), 0);
        peek("ovf_w0", A_TIMA, 8'h00);
        for (int k = 1; k < 4; k++) begin
            idle(1);
            check("ovf_win_irq", int'(timerIRQ), 0);
            peek("ovf_win", A_TIMA, 8'h00);
        end
        idle(1);
`endif
        check("ovf_irq", int'(timerIRQ), 1);
        peek("ovf_reload", A_TIMA, 8'hF0);
        idle(1);
        check("ovf_irq_end", int'(timerIRQ), 0);

        // TIMA write in the overflowing clock wins
        setup_overflow();
        wr(A_TIMA, 8'h99);
        check("wrwin_irq", int'(timerIRQ), 0);
        peek("wrwin_tima", A_TIMA, 8'h99);
        idle(6);
        peek("wrwin_hold", A_TIMA, 8'h99);

`ifdef TIMER_OVF_DELAY_EN
        // TIMA write inside the window cancels the reload
        setup_overflow();
        idle(2);
        wr(A_TIMA, 8'h42);
        peek("cancel_tima", A_TIMA, 8'h42);
        idle(4);
        peek("cancel_hold", A_TIMA, 8'h42);
`endif

        // TMA written in the reload clock is what TIMA loads
        setup_overflow();
`ifdef TIMER_OVF_DELAY_EN
        idle(4);
`endif
        wr(A_TMA, 8'hA5);
        check("tmald_irq", int'(timerIRQ), 1);
        peek("tmald_tima", A_TIMA, 8'hA5);

        // Reset in the middle of the overflow window
        setup_overflow();
        idle(2);
        #2 reset_n = 1'b0;
        #1 model_reset();
        check("rstmid_irq", int'(timerIRQ), 0);
        peek("rstmid_tima", A_TIMA, 8'h00);
        peek("rstmid_tma", A_TMA, 8'h00);
        peek("rstmid_tac", A_TAC, 8'hF8);
        peek("rstmid_div", A_DIV, 8'h00);
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            check("rstmid_irq_hold", int'(timerIRQ), 0);
        end
        reset_n = 1'b1;
        idle(8);
        check("post_rst_irq", int'(timerIRQ), 0);
        peek("post_rst_tima", A_TIMA, 8'h00);

        // Randomized traffic against the model
        for (int i = 0; i < 2000; i++) begin
            int          r;
            int          pick;
            logic [15:0] a;
            logic [7:0]  d;
            logic        c;
            r = $urandom_range(0, 99);
            if (r < 70) begin
                cyc(1'b1, 1'b0, 1'b0, A_DIV, 8'h00);
            end else begin
                pick = $urandom_range(0, 4);
                case (pick)
                    0: a = A_DIV;
                    1: a = A_TIMA;
                    2: a = A_TMA;
                    3: a = A_TAC;
                    default: a = 16'hFF08;
                endcase
                d = 8'($urandom_range(0, 255));
                if (pick == 1 && $urandom_range(0, 1) == 1) d = 8'hF0 | d[3:0];
                if (pick == 3 && $urandom_range(0, 2) != 0) d = 8'h05;
                c = ($urandom_range(0, 9) != 0);
                $display("rand   %0d cs=%b addr=%h data=%h", i, c, a, d);
                cyc(c, 1'b1, 1'b0, a, d);
            end
            pick = $urandom_range(0, 4);
            case (pick)
                0: a = A_DIV;
                1: a = A_TIMA;
                2: a = A_TMA;
                3: a = A_TAC;
                default: a = 16'hFF08;
            endcase
            cs_mmu = 1'b1; rd_mmu = 1'b1; A_mmu = a;
            #1;
            check("rand_read", int'(Do_mmu), exp_read(a));
            cs_mmu = 1'b0; rd_mmu = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/gb_timer_param.md
GB_TIMER_PARAM -- requirements
Module: gb_timer_param

Interface
REQ-001 SHALL have parameter DIV_W, default 16, width of the internal free-running divider (min 10).
REQ-002 SHALL have parameter BASE_ADDR, default 16'hFF04, address of DIV; TIMA/TMA/TAC at BASE_ADDR+1/+2/+3.
REQ-003 SHALL have parameters TAP0..TAP3, defaults 9/3/5/7, divider bit selected by TAC[1:0]=00/01/10/11.
REQ-004 SHALL have port clock  input  1  single system clock (one T-cycle per rising edge).
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port A_mmu  input  16  MMU address.
REQ-007 SHALL have port Di_mmu  input  8  MMU write data.
REQ-008 SHALL have port Do_mmu  output  8  MMU read data.
REQ-009 SHALL have port wr_mmu  input  1  write strobe, sampled on the rising clock edge.
REQ-010 SHALL have port rd_mmu  input  1  read strobe.
REQ-011 SHALL have port cs_mmu  input  1  chip select, qualifies rd_mmu/wr_mmu.
REQ-012 SHALL have port timerIRQ  output  1  one-clock interrupt request pulse on TIMA reload.

Function
REQ-013 Divider cnt[DIV_W-1:0] SHALL increment by 1 every clock and wrap to 0 after all-ones.
REQ-014 Any write to DIV SHALL clear cnt to 0 in that clock; data value ignored.
REQ-015 Reads SHALL be combinational: DIV -> cnt[DIV_W-1:DIV_W-8]; TIMA; TMA; TAC -> {5'b11111, TAC[2:0]}; other addresses or no cs&rd -> 8'h00.
REQ-016 Timer input SHALL be sig = TAC[2] & cnt[TAPsel]; TIMA SHALL increment on each clock where sig was 1 on the previous clock and is 0 now (falling-edge detect, all logic on clock, no derived clocks).
REQ-017 Falling edges caused by DIV write, TAC enable clear or TAC select change SHALL increment TIMA like normal edges.
REQ-018 TIMA increment from FF SHALL produce overflow; TIMA SHALL become 8'h00 that clock.
REQ-019 On reload, TIMA SHALL load TMA and timerIRQ SHALL be 1 for exactly that one clock.
REQ-020 CPU write to TIMA in the same clock as an increment SHALL win; no increment applied.
REQ-021 CPU write to TMA in the reload clock SHALL make TIMA load the new Di_mmu value.
REQ-022 TAC writes SHALL store Di_mmu[2:0]; upper bits discarded.

Reset
REQ-023 While reset_n=0: cnt=0, TIMA=0, TMA=0, TAC=0, edge-detect history=0, overflow state idle, timerIRQ=0.
REQ-024 Reset asserted mid-overflow window SHALL cancel the pending reload and IRQ.
REQ-025 After reset_n rises, first increment of cnt SHALL occur on the first rising clock edge.

Configuration
REQ-026 Macro TIMER_OVF_DELAY_EN SHALL select overflow timing.
REQ-027 With TIMER_OVF_DELAY_EN defined: overflow SHALL enter a 4-clock window with TIMA=00, reload+IRQ on the 4th clock after overflow; a TIMA write inside the window SHALL cancel reload and IRQ and store the written value.
REQ-028 Without TIMER_OVF_DELAY_EN: reload to TMA and IRQ pulse SHALL occur in the same clock as overflow; TIMA never reads 00 due to overflow.

Structure
REQ-029 Shared package timer_pkg SHALL hold register offset constants (DIV/TIMA/TMA/TAC), TAC field positions, and overflow-state enum (IDLE, WAIT, RELOAD).
REQ-030 Sub-module timer_div_counter SHALL contain cnt, tap mux and falling-edge detect, outputting DIV byte and a one-clock tick.
REQ-031 Register decode, TIMA/TMA/TAC and overflow FSM SHALL reside in gb_timer_param.

Verification
REQ-032 TAC=3'b101, TIMA=00 -> TIMA=01 after 16 clocks, 02 after 32 clocks.
REQ-033 TAC=3'b100, TMA=8'hF0, TIMA=8'hFF, run 1024 clocks -> overflow; macro on: TIMA=00 for 4 clocks then F0 with 1-clock timerIRQ; macro off: F0 and IRQ same clock.
REQ-034 Macro on, overflow, write TIMA=8'h42 on clock 2 of window -> TIMA=42, no IRQ, no reload.
REQ-035 TAC=3'b101, wait until cnt[3]=1, write DIV -> cnt=0, TIMA increments by 1 immediately.
REQ-036 Assert reset_n=0 inside overflow window -> all registers 0, timerIRQ stays 0; read TAC -> 8'hF8.
